// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control path: sequencer states, default
// widths, key indices and the opcode encodings understood by the ALU core.
package alu_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_OP_W   = 4;

    // Bit positions of the three pushbuttons inside the key vectors
    localparam int KEY_A    = 0;
    localparam int KEY_B    = 1;
    localparam int KEY_C    = 2;
    localparam int NUM_KEYS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        LCD   = 2'd3
    } state_t;

    localparam logic [DEF_OP_W-1:0] OPC_ADD = 4'h0;
    localparam logic [DEF_OP_W-1:0] OPC_SUB = 4'h1;
    localparam logic [DEF_OP_W-1:0] OPC_AND = 4'h2;
    localparam logic [DEF_OP_W-1:0] OPC_OR  = 4'h3;
    localparam logic [DEF_OP_W-1:0] OPC_XOR = 4'h4;
    localparam logic [DEF_OP_W-1:0] OPC_SHL = 4'h5;
    localparam logic [DEF_OP_W-1:0] OPC_SHR = 4'h6;
    localparam logic [DEF_OP_W-1:0] OPC_MUL = 4'h7;

endpackage

// File: rtl/key_debouncer.sv
// Raw active-low pushbutton -> 2-FF synchronizer -> debounced level ->
// one-cycle pulse on the accepted press (high-to-low) transition.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Released (1) is the reset level so a key held through reset is seen as a fresh press
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level_d & ~r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/alu_key_sequencer.sv
// Captures operands/opcode from the switch word on debounced key presses,
// launches the ALU, waits for done or timeout, then requests an LCD refresh.
module alu_key_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int OP_W            = DEF_OP_W,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              key_a_n,
    input  logic              key_b_n,
    input  logic              key_c_n,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    output logic [OP_W-1:0]   opcode_o,
    output logic              alu_start_o,
    input  logic              alu_done_i,
    output logic              lcd_req_o,
    input  logic              lcd_ack_i,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [NUM_KEYS-1:0] w_keys_n;
    logic [NUM_KEYS-1:0] w_press;

    assign w_keys_n[KEY_A] = key_a_n;
    assign w_keys_n[KEY_B] = key_b_n;
    assign w_keys_n[KEY_C] = key_c_n;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .i_clk  (clk_i),
                .i_rst  (rst_i),
                .i_key_n(w_keys_n[gi]),
                .o_press(w_press[gi])
            );
        end
    endgenerate

    state_t            r_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [OP_W-1:0]   r_opcode;
    logic              r_alu_start;
    logic              r_lcd_req;
    logic              r_busy;
    logic              r_timeout;

    logic [TO_W-1:0]   w_to_cnt_next;
    logic              w_to_hit;

    // Saturating wait counter; the timeout fires on the edge it reaches its last value
    assign w_to_cnt_next = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + 1'b1;
    assign w_to_hit      = (w_to_cnt_next >= TO_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_to_cnt    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_opcode    <= '0;
            r_alu_start <= 1'b0;
            r_lcd_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    // All simultaneous presses load together, so START sees fresh operands
                    if (w_press[KEY_A]) r_op_a <= data_i;
                    if (w_press[KEY_B]) r_op_b <= data_i;
                    if (w_press[KEY_C]) begin
                        r_opcode    <= data_i[OP_W-1:0];
                        r_state     <= START;
                        r_alu_start <= 1'b1;
                        r_timeout   <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                START: begin
                    r_state   <= WAIT;
                    r_to_cnt  <= '0;
                    r_timeout <= 1'b0;
                end
                WAIT: begin
                    if (alu_done_i) begin
                        r_state   <= LCD;
                        r_lcd_req <= 1'b1;
                    end else if (w_to_hit) begin
                        r_state   <= LCD;
                        r_lcd_req <= 1'b1;
                        r_timeout <= 1'b1;
                        r_to_cnt  <= w_to_cnt_next;
                    end else begin
                        r_to_cnt <= w_to_cnt_next;
                    end
                end
                LCD: begin
                    if (lcd_ack_i) begin
                        r_state   <= IDLE;
                        r_lcd_req <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_lcd_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign op_a_o      = r_op_a;
    assign op_b_o      = r_op_b;
    assign opcode_o    = r_opcode;
    assign alu_start_o = r_alu_start;
    assign lcd_req_o   = r_lcd_req;
    assign busy_o      = r_busy;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_alu_key_sequencer.sv
// Directed bench for alu_key_sequencer with a small expected-value scoreboard.
module tb_alu_key_sequencer;

    localparam int DW = 16;
    localparam int OW = 4;
    localparam int DB = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          key_a_n = 1'b1;
    logic          key_b_n = 1'b1;
    logic          key_c_n = 1'b1;
    logic          alu_done = 1'b0;
    logic          lcd_ack = 1'b0;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [OW-1:0] opcode;
    logic          alu_start;
    logic          lcd_req;
    logic          busy;
    logic          timeout;

    alu_key_sequencer #(
        .DATA_W         (DW),
        .OP_W           (OW),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_i     (data_i),
        .key_a_n    (key_a_n),
        .key_b_n    (key_b_n),
        .key_c_n    (key_c_n),
        .op_a_o     (op_a),
        .op_b_o     (op_b),
        .opcode_o   (opcode),
        .alu_start_o(alu_start),
        .alu_done_i (alu_done),
        .lcd_req_o  (lcd_req),
        .lcd_ack_i  (lcd_ack),
        .busy_o     (busy),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;

    always @(negedge clk) if (alu_start === 1'b1) start_cnt++;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    function automatic logic sig(input int sel);
        return (sel == 0) ? alu_start : lcd_req;
    endfunction

    task automatic wait_sig(input string tag, input int sel, input int budget, output int cycles);
        cycles = 0;
        while (sig(sel) !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (sig(sel) !== 1'b1) check({tag, "_wait_expired"}, 32'(sig(sel)), 32'd1);
    endtask

    task automatic press(input logic a, input logic b, input logic c, input logic [DW-1:0] d);
        @(negedge clk);
        data_i = d;
        if (a) key_a_n = 1'b0;
        if (b) key_b_n = 1'b0;
        if (c) key_c_n = 1'b0;
    endtask

    task automatic release_all();
        @(negedge clk);
        key_a_n = 1'b1;
        key_b_n = 1'b1;
        key_c_n = 1'b1;
        repeat (DB + 8) @(negedge clk);
    endtask

    task automatic alu_done_after(input int n);
        repeat (n) @(negedge clk);
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        lcd_ack = 1'b1;
        @(negedge clk);
        lcd_ack = 1'b0;
        check("lcd_req_dropped", 32'(lcd_req), 32'd0);
        check("busy_after_ack", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int s0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_op_a", 32'(op_a), 32'd0);
        check("rst_op_b", 32'(op_b), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_lcd_req", 32'(lcd_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        // Clean A then B captures with exact latency
        sb_push("op_a_capture", 32'h1234);
        press(1'b1, 1'b0, 1'b0, 16'h1234);
        repeat (DB + 3) @(negedge clk);
        check("op_a_early", 32'(op_a), 32'd0);
        @(negedge clk);
        sb_pop_check(32'(op_a));
        check("busy_after_a", 32'(busy), 32'd0);
        release_all();

        sb_push("op_b_capture", 32'h00FF);
        press(1'b0, 1'b1, 1'b0, 16'h00FF);
        repeat (DB + 3) @(negedge clk);
        check("op_b_early", 32'(op_b), 32'd0);
        @(negedge clk);
        sb_pop_check(32'(op_b));
        check("op_a_kept", 32'(op_a), 32'h1234);
        check("busy_after_b", 32'(busy), 32'd0);
        release_all();

        // Bouncing A key: no capture while bouncing, exactly one afterwards
        sb_push("op_a_bounce_capture", 32'hBEEF);
        @(negedge clk);
        data_i = 16'hBEEF;
        for (int i = 0; i < 6; i++) begin
            key_a_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk);
        end
        check("bounce_no_capture", 32'(op_a), 32'h1234);
        key_a_n = 1'b0;
        repeat (DB + 4) @(negedge clk);
        sb_pop_check(32'(op_a));
        data_i = 16'h1111;
        repeat (10) @(negedge clk);
        check("bounce_single_capture", 32'(op_a), 32'hBEEF);
        release_all();

        // Normal operation, ALU answers 5 cycles after start
        s0 = start_cnt;
        sb_push("opcode_exec", 32'h3);
        press(1'b0, 1'b0, 1'b1, 16'h0003);
        wait_sig("start", 0, 20, cyc);
        sb_pop_check(32'(opcode));
        check("busy_in_start", 32'(busy), 32'd1);
        alu_done_after(5);
        wait_sig("lcd", 1, 40, cyc);
        repeat (3) @(negedge clk);
        check("lcd_req_held", 32'(lcd_req), 32'd1);
        check("timeout_clear_done", 32'(timeout), 32'd0);
        do_ack();
        check("single_start", 32'(start_cnt - s0), 32'd1);
        release_all();

        // ALU never answers: timeout path
        press(1'b0, 1'b0, 1'b1, 16'h0005);
        wait_sig("start_to", 0, 20, cyc);
        wait_sig("lcd_to", 1, 40, cyc);
        check("timeout_latency", 32'(cyc), 32'd16);
        check("timeout_set", 32'(timeout), 32'd1);
        check("opcode_to", 32'(opcode), 32'h5);
        do_ack();
        check("timeout_sticky", 32'(timeout), 32'd1);
        release_all();

        // Next successful operation clears the timeout flag
        press(1'b0, 1'b0, 1'b1, 16'h0003);
        wait_sig("start_clr", 0, 20, cyc);
        check("timeout_cleared_at_start", 32'(timeout), 32'd0);
        alu_done_after(2);
        wait_sig("lcd_clr", 1, 40, cyc);
        do_ack();
        check("timeout_cleared", 32'(timeout), 32'd0);
        release_all();

        // A press during WAIT is discarded
        press(1'b0, 1'b0, 1'b1, 16'h0006);
        wait_sig("start_w", 0, 20, cyc);
        press(1'b1, 1'b0, 1'b0, 16'hAAAA);
        wait_sig("lcd_w", 1, 40, cyc);
        do_ack();
        repeat (3) @(negedge clk);
        check("op_a_frozen", 32'(op_a), 32'hBEEF);
        release_all();

        // Same-cycle A and C presses: START uses the new operand
        sb_push("op_a_same_cycle", 32'h5A5A);
        sb_push("opcode_same_cycle", 32'hA);
        press(1'b1, 1'b0, 1'b1, 16'h5A5A);
        wait_sig("start_ac", 0, 20, cyc);
        sb_pop_check(32'(op_a));
        sb_pop_check(32'(opcode));
        check("op_b_same_cycle", 32'(op_b), 32'h00FF);
        alu_done_after(1);
        wait_sig("lcd_ac", 1, 40, cyc);
        do_ack();
        release_all();

        // Asynchronous reset while an LCD request is outstanding
        press(0, 0, 1, 16'h0007);
        wait_sig("start_rst", 0, 20, cyc);
        alu_done_after(3);
        wait_sig("lcd_rst", 1, 40, cyc);
        key_a_n = 1'b1;
        key_b_n = 1'b1;
        key_c_n = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_lcd_req", 32'(lcd_req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_op_a", 32'(op_a), 32'd0);
        check("arst_op_b", 32'(op_b), 32'd0);
        check("arst_opcode", 32'(opcode), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        s0 = start_cnt;
        repeat (20) @(negedge clk);
        check("no_spurious_start", 32'(start_cnt - s0), 32'd0);
        check("no_spurious_busy", 32'(busy), 32'd0);
        check("no_spurious_op_a", 32'(op_a), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
